// File: rtl/exp2_shift_pkg.sv
// ============================================================================
// Module      : exp2_shift_pkg
// Description : Shared constants, types and helpers for the exp2 power-of-two
//               stage of the softmax exponent path.
//               - OUTPUT_BUF_DATASIZE / FIXPOINT_FRAC : datapath widths
//               - EXP2_SAT_SHIFT  : smallest u that saturates the output
//               - EXP2_ZERO_SHIFT : magnitude of the largest u that underflows
//               - shift_dir_e     : barrel-shift direction
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package exp2_shift_pkg;

    localparam int OUTPUT_BUF_DATASIZE = 32;
    localparam int FIXPOINT_FRAC       = 10;

    // Any u at or above this leaves no room for the 1+FRAC_W mantissa bits.
    function automatic int exp2_sat_shift(input int data_w, input int frac_w);
        return data_w - frac_w;
    endfunction

    // Any u at or below minus this shifts the mantissa entirely out.
    function automatic int exp2_zero_shift(input int frac_w);
        return frac_w + 1;
    endfunction

    localparam int EXP2_SAT_SHIFT  = exp2_sat_shift(OUTPUT_BUF_DATASIZE, FIXPOINT_FRAC);
    localparam int EXP2_ZERO_SHIFT = exp2_zero_shift(FIXPOINT_FRAC);

    typedef enum logic {
        SHIFT_RIGHT = 1'b0,
        SHIFT_LEFT  = 1'b1
    } shift_dir_e;

endpackage : exp2_shift_pkg

`default_nettype wire

// File: rtl/exp2_barrel.sv
// ============================================================================
// Module      : exp2_barrel
// Description : Combinational barrel shift of the Q1.FRAC_W mantissa into the
//               DATA_W output format, with saturation and underflow override.
// Ports       : m_i      - mantissa 1.v (FRAC_W+1 bits)
//               dir_i    - shift direction
//               amt_i    - shift magnitude
//               sat_i    - force all ones
//               zero_i   - force zero
//               result_o - DATA_W unsigned fixed-point result
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module exp2_barrel
    import exp2_shift_pkg::*;
#(
    parameter int DATA_W = OUTPUT_BUF_DATASIZE,
    parameter int FRAC_W = FIXPOINT_FRAC,
    parameter int AMT_W  = $clog2(DATA_W)
) (
    input  logic [FRAC_W:0]   m_i,
    input  shift_dir_e        dir_i,
    input  logic [AMT_W-1:0]  amt_i,
    input  logic              sat_i,
    input  logic              zero_i,
    output logic [DATA_W-1:0] result_o
);

    logic [DATA_W-1:0] w_m_ext;
    logic [DATA_W-1:0] w_left;
    logic [DATA_W-1:0] w_right;

    assign w_m_ext = {{(DATA_W-FRAC_W-1){1'b0}}, m_i};

    // Left shifts stay below DATA_W-FRAC_W, so no mantissa bit is lost;
    // right shifts truncate toward zero.
    assign w_left  = w_m_ext << amt_i;
    assign w_right = w_m_ext >> amt_i;

    always_comb begin
        result_o = '0;
        if (sat_i) begin
            result_o = '1;
        end else if (zero_i) begin
            result_o = '0;
        end else if (dir_i == SHIFT_LEFT) begin
            result_o = w_left;
        end else begin
            result_o = w_right;
        end
    end

endmodule : exp2_barrel

`default_nettype wire

// File: rtl/exp2_shift.sv
// ============================================================================
// Module      : exp2_shift
// Description : Two-stage elastic pipeline computing 2^(u+v) ~ (1+v)*2^u as
//               an unsigned Q(DATA_W-FRAC_W).FRAC_W value, plus a saturating
//               per-row accumulator of the stage-2 exponentials.
// Ports       : clk, rst_n               - clock, synchronous active-low reset
//               in_valid/in_ready        - input handshake
//               u, v, in_last, is_stage2 - input beat
//               out_valid/out_ready      - output handshake
//               out_data, out_last       - output beat
//               sum_valid, sum_data      - row-sum pulse and held value
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module exp2_shift
    import exp2_shift_pkg::*;
#(
    parameter int DATA_W = OUTPUT_BUF_DATASIZE,
    parameter int FRAC_W = FIXPOINT_FRAC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] u,
    input  logic [FRAC_W-1:0] v,
    input  logic              in_last,
    input  logic              is_stage2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              sum_valid,
    output logic [DATA_W-1:0] sum_data
);

    localparam int AMT_W = $clog2(DATA_W);

    localparam logic signed [DATA_W-1:0] SAT_LIM  =
        DATA_W'(exp2_sat_shift(DATA_W, FRAC_W));
    localparam logic signed [DATA_W-1:0] ZERO_LIM =
        -(DATA_W'(exp2_zero_shift(FRAC_W)));

    // ------------------------------------------------------------------
    // Stage S1: range decode of u and mantissa formation
    // ------------------------------------------------------------------
    logic              s1_valid_q;
    logic [FRAC_W:0]   s1_m_q,    s1_m_d;
    logic              s1_sat_q,  s1_sat_d;
    logic              s1_zero_q, s1_zero_d;
    shift_dir_e        s1_dir_q,  s1_dir_d;
    logic [AMT_W-1:0]  s1_amt_q,  s1_amt_d;
    logic              s1_last_q;
    logic              s1_stg2_q;

    // ------------------------------------------------------------------
    // Stage S2: output registers
    // ------------------------------------------------------------------
    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic              out_last_q;
    logic              out_stg2_q;

    // ------------------------------------------------------------------
    // Accumulator
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] acc_q;
    logic              sum_valid_q;
    logic [DATA_W-1:0] sum_data_q;

    logic              w_s2_adv;
    logic              w_in_fire;
    logic              w_out_fire;
    logic [DATA_W-1:0] w_shift_result;
    logic [DATA_W:0]   w_acc_sum;
    logic [DATA_W-1:0] w_acc_sat;

    // The output register can take a new beat when it is empty or its
    // current beat is leaving this cycle; S1 likewise relative to S2.
    assign w_s2_adv   = !out_valid_q || out_ready;
    assign in_ready   = !s1_valid_q || w_s2_adv;
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = out_valid_q && out_ready;

    assign s1_m_d    = {1'b1, v};
    assign s1_sat_d  = $signed(u) >= SAT_LIM;
    assign s1_zero_d = $signed(u) <= ZERO_LIM;
    assign s1_dir_d  = u[DATA_W-1] ? SHIFT_RIGHT : SHIFT_LEFT;
    // Only the low AMT_W bits matter once the range flags cover the rest;
    // the low bits of -u depend only on the low bits of u.
    assign s1_amt_d  = u[DATA_W-1] ? ({AMT_W{1'b0}} - u[AMT_W-1:0])
                                   : u[AMT_W-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_m_q     <= '0;
            s1_sat_q   <= 1'b0;
            s1_zero_q  <= 1'b0;
            s1_dir_q   <= SHIFT_LEFT;
            s1_amt_q   <= '0;
            s1_last_q  <= 1'b0;
            s1_stg2_q  <= 1'b0;
        end else begin
            if (in_ready) begin
                s1_valid_q <= in_valid;
            end
            if (w_in_fire) begin
                s1_m_q    <= s1_m_d;
                s1_sat_q  <= s1_sat_d;
                s1_zero_q <= s1_zero_d;
                s1_dir_q  <= s1_dir_d;
                s1_amt_q  <= s1_amt_d;
                s1_last_q <= in_last;
                s1_stg2_q <= is_stage2;
            end
        end
    end

    exp2_barrel #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W),
        .AMT_W  (AMT_W)
    ) u_barrel (
        .m_i      (s1_m_q),
        .dir_i    (s1_dir_q),
        .amt_i    (s1_amt_q),
        .sat_i    (s1_sat_q),
        .zero_i   (s1_zero_q),
        .result_o (w_shift_result)
    );

    // Output registers only change when advancing, so they hold while
    // out_ready is low with a valid beat presented.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_stg2_q  <= 1'b0;
        end else if (w_s2_adv) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_data_q <= w_shift_result;
                out_last_q <= s1_last_q;
                out_stg2_q <= s1_stg2_q;
            end
        end
    end

    // Saturating add of the beat currently leaving the pipe.
    assign w_acc_sum = {1'b0, acc_q} + {1'b0, out_data_q};
    assign w_acc_sat = w_acc_sum[DATA_W] ? {DATA_W{1'b1}} : w_acc_sum[DATA_W-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q       <= '0;
            sum_valid_q <= 1'b0;
            sum_data_q  <= '0;
        end else begin
            sum_valid_q <= 1'b0;
            if (w_out_fire && out_stg2_q) begin
                if (out_last_q) begin
                    sum_data_q  <= w_acc_sat;
                    sum_valid_q <= 1'b1;
                    acc_q       <= '0;
                end else begin
                    acc_q <= w_acc_sat;
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign sum_valid = sum_valid_q;
    assign sum_data  = sum_data_q;

endmodule : exp2_shift

`default_nettype wire

// File: tb/tb_exp2_shift.sv
// ============================================================================
// Module      : tb_exp2_shift
// Description : Directed self-checking bench for exp2_shift (default widths,
//               DATA_W=32, FRAC_W=10).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_exp2_shift;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] u;
    logic [9:0]  v;
    logic        in_last;
    logic        is_stage2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;
    logic        sum_valid;
    logic [31:0] sum_data;

    int n_checks = 0;
    int n_fail   = 0;

    exp2_shift #(
        .DATA_W (32),
        .FRAC_W (10)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .u         (u),
        .v         (v),
        .in_last   (in_last),
        .is_stage2 (is_stage2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .sum_valid (sum_valid),
        .sum_data  (sum_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One isolated beat: out_valid must be low one cycle after the input
    // handshake and high with the expected value after two.
    task automatic single(input string tag, input logic [31:0] uu,
                          input logic [9:0] vv, input logic [31:0] expv);
        u = uu; v = vv; in_valid = 1'b1; in_last = 1'b0; is_stage2 = 1'b0;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check({tag, "_lat1"}, 32'(out_valid), 32'd0);
        step();
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_data"}, out_data, expv);
        step();
    endtask

    // Stream n identical beats with out_ready high; check every output,
    // the number of sum pulses, the sum value and the pulse timing.
    task automatic stream(input string tag, input int n, input logic [31:0] uu,
                          input logic [9:0] vv, input logic stg2, input logic with_last,
                          input logic [31:0] exp_data, input int exp_pulses,
                          input logic [31:0] exp_sum);
        int          sent      = 0;
        int          rcv       = 0;
        int          pulses    = 0;
        int          last_fire = -10;
        int          pulse_at  = -1;
        logic [31:0] got_sum   = '0;
        logic        fire_in;
        logic        fire_out;
        out_ready = 1'b1;
        for (int c = 0; c < n + 8; c++) begin
            in_valid  = (sent < n);
            u         = uu;
            v         = vv;
            is_stage2 = stg2;
            in_last   = with_last && (sent == n - 1);
            #1;
            fire_in  = in_valid && in_ready;
            fire_out = out_valid && out_ready;
            if (sum_valid) begin
                pulses++;
                got_sum  = sum_data;
                pulse_at = c;
            end
            if (fire_out) begin
                check({tag, "_data"}, out_data, exp_data);
                check({tag, "_last"}, 32'(out_last), 32'(with_last && (rcv == n - 1)));
                if (out_last) last_fire = c;
                rcv++;
            end
            if (fire_in) sent++;
            step();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check({tag, "_count"}, 32'(rcv), 32'(n));
        check({tag, "_pulses"}, 32'(pulses), 32'(exp_pulses));
        if (exp_pulses > 0) begin
            check({tag, "_sum"}, got_sum, exp_sum);
            check({tag, "_pulse_cycle"}, 32'(pulse_at), 32'(last_fire + 1));
        end
    endtask

    int          bp_sent;
    int          bp_rcv;
    logic        bp_prev_stall;
    logic [31:0] bp_prev_data;
    logic        bp_saw_block;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; u = '0; v = '0; in_last = 1'b0;
        is_stage2 = 1'b0; out_ready = 1'b1;

        // Reset state
        step(); step(); step();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  out_data, 32'd0);
        check("rst_out_last",  32'(out_last), 32'd0);
        check("rst_sum_valid", 32'(sum_valid), 32'd0);
        check("rst_sum_data",  sum_data, 32'd0);
        check("rst_in_ready",  32'(in_ready), 32'd1);
        rst_n = 1'b1;
        step();

        // Basic values
        single("u0_v0",    32'd0,          10'h000, 32'h0000_0400);
        single("um1_v200", 32'hFFFF_FFFF,  10'h200, 32'h0000_0300);
        single("u3_v3ff",  32'd3,          10'h3FF, 32'h0000_3FF8);
        // Boundaries
        single("u21_v3ff", 32'd21,         10'h3FF, 32'hFFE0_0000);
        single("u22",      32'd22,         10'h000, 32'hFFFF_FFFF);
        single("umin",     32'h8000_0000,  10'h3FF, 32'h0000_0000);
        single("um10",     32'hFFFF_FFF6,  10'h000, 32'h0000_0001);
        single("um11",     32'hFFFF_FFF5,  10'h3FF, 32'h0000_0000);
        check("basic_no_sum", 32'(sum_valid), 32'd0);

        // Backpressure: 8 beats, u = beat index, out_ready low 3 cycles
        bp_sent = 0; bp_rcv = 0; bp_prev_stall = 1'b0; bp_prev_data = '0;
        bp_saw_block = 1'b0;
        for (int c = 0; c < 40 && bp_rcv < 8; c++) begin
            out_ready = !(c >= 4 && c < 7);
            in_valid  = (bp_sent < 8);
            u = 32'(bp_sent); v = '0; is_stage2 = 1'b0; in_last = 1'b0;
            #1;
            if (bp_prev_stall) begin
                check("bp_hold_valid", 32'(out_valid), 32'd1);
                check("bp_hold_data", out_data, bp_prev_data);
            end
            if (!in_ready) bp_saw_block = 1'b1;
            if (out_valid && out_ready) begin
                check("bp_data", out_data, 32'h400 << bp_rcv);
                bp_rcv++;
            end
            if (in_valid && in_ready) bp_sent++;
            bp_prev_stall = out_valid && !out_ready;
            bp_prev_data  = out_data;
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check("bp_count", 32'(bp_rcv), 32'd8);
        check("bp_in_ready_low", 32'(bp_saw_block), 32'd1);
        step(); step();
        check("bp_drained", 32'(out_valid), 32'd0);

        // Accumulation rows
        stream("row4",  4, 32'd0, 10'h000, 1'b1, 1'b1, 32'h0000_0400, 1, 32'h0000_1000);
        stream("row2",  2, 32'd1, 10'h000, 1'b1, 1'b1, 32'h0000_0800, 1, 32'h0000_1000);
        // Stage-4 beats never produce a sum
        stream("stg4",  1, 32'd2, 10'h000, 1'b0, 1'b1, 32'h0000_1000, 0, 32'h0);
        stream("stg4b", 1, 32'd0, 10'h000, 1'b0, 1'b1, 32'h0000_0400, 0, 32'h0);
        check("stg4_sum_held", sum_data, 32'h0000_1000);
        // Saturating accumulation
        stream("satrow", 2, 32'd22, 10'h000, 1'b1, 1'b1, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF);

        // Reset mid-row: two beats accumulated, two more in flight
        stream("pre_rst", 2, 32'd0, 10'h000, 1'b1, 1'b0, 32'h0000_0400, 0, 32'h0);
        u = '0; v = '0; is_stage2 = 1'b1; in_last = 1'b0; in_valid = 1'b1;
        out_ready = 1'b1;
        step();
        step();
        in_valid = 1'b0;
        check("inflight_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        step();
        check("mrst_out_valid", 32'(out_valid), 32'd0);
        check("mrst_out_data",  out_data, 32'd0);
        check("mrst_out_last",  32'(out_last), 32'd0);
        check("mrst_sum_valid", 32'(sum_valid), 32'd0);
        check("mrst_sum_data",  sum_data, 32'd0);
        check("mrst_in_ready",  32'(in_ready), 32'd1);
        rst_n = 1'b1;
        step();
        check("post_rst_idle", 32'(out_valid), 32'd0);
        stream("row1", 1, 32'd0, 10'h000, 1'b1, 1'b1, 32'h0000_0400, 1, 32'h0000_0400);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_exp2_shift

`default_nettype wire

// File: doc/exp2_shift.md
# exp2_shift

Pipelined power-of-two stage of the softmax exponent path. It consumes the integer part `u` and fractional part `v` of x·log2e produced by the preprocess stage, and forms 2^(u+v) ≈ (1+v)·2^u as an unsigned fixed-point value. During stage 2 it also accumulates each row's exponentials into the denominator F, which later feeds the lnF computation. In stage 4 it emits the final softmax values, with the accumulator idle.

## Interface
Parameters:
- `DATA_W`, default `OUTPUT_BUF_DATASIZE` (32): width of `u`, `out_data` and `sum_data`.
- `FRAC_W`, default `FIXPOINT_FRAC` (10): width of `v`; number of fractional bits of the output.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `in_valid` in 1: input beat valid.
- `in_ready` out 1: stage can accept a beat.
- `u` in DATA_W: signed two's-complement integer part (floor).
- `v` in FRAC_W: unsigned fraction, Q0.FRAC_W.
- `in_last` in 1: last element of a row.
- `is_stage2` in 1: beat belongs to stage 2 (accumulate); sampled per beat.
- `out_valid` out 1: output beat valid.
- `out_ready` in 1: downstream accepts.
- `out_data` out DATA_W: unsigned Q(DATA_W−FRAC_W).FRAC_W result.
- `out_last` out 1: `in_last` carried through the pipeline.
- `sum_valid` out 1: one-cycle pulse, row sum valid.
- `sum_data` out DATA_W: row sum, same Q format; held until the next pulse.

## Operation
- Mantissa: m = 2^FRAC_W + v, 11 bits (Q1.10, linear approximation 2^v ≈ 1+v).
- Shift:
  - u ≥ 0: out = m << u.
  - u < 0: out = m >> (−u), truncating.
- Saturation and underflow:
  - u ≥ DATA_W−FRAC_W (22): out = all ones.
  - u ≤ −(FRAC_W+1) (−11): out = 0.
  - Comparisons are signed on the full DATA_W of `u`.
- Stage S1 registers m, a saturate flag, a zero flag, the shift amount and its direction (5 bits of magnitude suffice after the range checks), plus `in_last` and `is_stage2`.
- Stage S2 performs the barrel shift and saturation mux into the `out_data` register.
- Accumulator (acc, DATA_W bits, saturating add), applied on each output handshake (`out_valid` && `out_ready`) whose carried stage2 flag is 1:
  - not last: acc ← sat(acc + out_data).
  - last: sum_data ← sat(acc + out_data); sum_valid pulses the next cycle; acc ← 0.
- Beats with stage2 = 0 never touch acc or sum.
- `sum_valid` has no backpressure; the consumer must take it in the pulse cycle.

## Timing
- Latency is 2 cycles from input handshake to `out_valid`, with `out_ready` held high.
- Throughput is 1 beat/cycle.
- Handshake and stall:
  - Elastic pipeline: each stage advances when it is empty or the next stage advances.
  - `in_ready` = !s1_valid || s1 advancing.
  - With `out_ready` low, the `out_data`, `out_last` and `out_valid` registers hold stable.
  - No beat is dropped or duplicated.
  - `in_ready` may depend combinationally on `out_ready`.
- `sum_valid` asserts the cycle after the last beat's output handshake.
- `sum_data` updates in that same cycle.
- Reset values: `out_valid` 0, `out_data` 0, `out_last` 0, `sum_valid` 0, `sum_data` 0, acc 0, all internal valids 0.
  - `in_ready` is 1 after reset.
- Reset mid-operation: in-flight beats are discarded, a partial acc is lost, and no `sum_valid` is emitted for the interrupted row.
- A simultaneous input and output handshake with a full pipeline is legal and shifts the pipe by one beat.
- A row of length 1 (`in_last` on the first beat) gives sum_data = that beat's out_data.

## Structure
- `OUTPUT_BUF_DATASIZE` and `FIXPOINT_FRAC` come from the shared `config.v`.
- Add `EXP2_SAT_SHIFT` (DATA_W−FRAC_W) and `EXP2_ZERO_SHIFT` (FRAC_W+1) to `config.v`.
- One sub-module, `exp2_barrel`: combinational shift plus saturation and zero mux.
  - Inputs: m, direction, amount, saturate flag, zero flag.
  - Outputs: the DATA_W result.
- Pipeline registers, handshake logic and the accumulator stay in `exp2_shift`.

## Test plan
- Basic values, `out_ready` = 1:
  - u=0, v=0 → out 0x0000_0400 after 2 cycles.
  - u=−1, v=0x200 → 0x0000_0300.
  - u=3, v=0x3FF → 0x0000_3FF8.
- Boundaries:
  - u=21, v=0x3FF → 0xFFE0_0000.
  - u=22 → 0xFFFF_FFFF.
  - u=0x8000_0000 → 0.
  - u=−10, v=0 → 0x1.
  - u=−11 → 0.
- Backpressure: stream 8 beats while holding `out_ready` low for 3 cycles mid-stream → all 8 outputs arrive in order, `out_data` stable while stalled, `in_ready` low once the pipe is full.
- Accumulation:
  - 4 stage2 beats (u=0, v=0), last on the 4th → one `sum_valid` pulse with sum_data 0x1000.
  - Next row of 2 beats (u=1, v=0) → 0x1000.
- Stage 4 and saturation:
  - Beats with `is_stage2`=0 and last=1 → no `sum_valid`.
  - Two stage2 beats with u=22 → sum_data 0xFFFF_FFFF.
- Reset mid-row: 2 stage2 beats, then `rst_n` low for 1 cycle, then a 1-beat row (u=0, v=0, last) → all outputs 0 during reset, then sum_data 0x400.
